// File: rtl/adder4_pkg.sv
// adder4_pkg
//   Shared definitions for the nibble-serial adder controller:
//   slice width, controller state type and the index-width helper.
package adder4_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of the nibble index; never below one bit so the register exists.
   function automatic int idx_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/adder4_seq_ci.sv
// adder4_ci
//   Combinational 4-bit ripple adder slice with carry-in.
//   Ports:
//     a, b  in  4  addends
//     ci    in  1  carry-in
//     s     out 4  sum
//     c4    out 1  carry-out
module adder4_ci
   import adder4_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                c4
);

   assign {c4, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};

endmodule

// File: rtl/adder4_seq_ctrl.sv
// adder4_seq_ctrl
//   Nibble-serial multi-word adder. One shared 4-bit slice processes the
//   operands LSB nibble first, one nibble per clock, with a registered
//   carry between nibbles. Operands and result use valid/ready handshakes.
//
//   Optional build macro ADDER4_SEQ_SUB_EN adds the 'op' input:
//   op=1 computes a-b (b inverted, initial carry forced to 1, cout=1 means
//   no borrow); op=0 or macro undefined gives plain addition.
//
//   Ports:
//     clk        in   1  system clock, rising edge
//     rst        in   1  asynchronous active-high reset
//     in_valid   in   1  operand pair valid
//     in_ready   out  1  controller can accept operands (state==IDLE)
//     a, b       in   W  operands, W = 4*NIBBLES
//     cin        in   1  carry-in to nibble 0
//     op         in   1  (ADDER4_SEQ_SUB_EN only) 1 = subtract
//     out_valid  out  1  result valid (state==DONE)
//     out_ready  in   1  consumer accepts result
//     sum        out  W  registered result
//     cout       out  1  carry-out of the top nibble
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | feeding nibble idx through the slice, one per clock
//   DONE  | result held on sum/cout with out_valid=1 until out_ready
module adder4_seq_ctrl
   import adder4_pkg::*;
#(
   parameter int NIBBLES = 4
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   input  logic                        cin,
`ifdef ADDER4_SEQ_SUB_EN
   input  logic                        op,
`endif
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
   output logic                        cout
);

   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int IW = idx_width(NIBBLES);
   localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

   state_e              state;
   logic [W-1:0]        a_r;
   logic [W-1:0]        b_r;
   logic [W-1:0]        sum_r;
   logic                carry;
   logic                cout_r;
   logic [IW-1:0]       idx;

   logic [NIBBLE_W-1:0] slice_a;
   logic [NIBBLE_W-1:0] slice_b;
   logic [NIBBLE_W-1:0] slice_s;
   logic                slice_c4;

   logic                accept;
   logic [W-1:0]        b_in;
   logic                carry_in;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign sum       = sum_r;
   assign cout      = cout_r;

`ifdef ADDER4_SEQ_SUB_EN
   // Two's-complement subtract: a + ~b + 1.
   assign b_in     = op ? ~b : b;
   assign carry_in = op | cin;
`else
   assign b_in     = b;
   assign carry_in = cin;
`endif

   // Nibble mux written as a compare loop so every select is constant.
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx == IW'(i)) begin
            slice_a = a_r[i*NIBBLE_W +: NIBBLE_W];
            slice_b = b_r[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   adder4_ci u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry),
      .s  (slice_s),
      .c4 (slice_c4)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         sum_r  <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         idx    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_r    <= a;
                  b_r    <= b_in;
                  carry  <= carry_in;
                  idx    <= '0;
                  sum_r  <= '0;
                  cout_r <= 1'b0;
                  state  <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < NIBBLES; i++) begin
                  if (idx == IW'(i)) begin
                     sum_r[i*NIBBLE_W +: NIBBLE_W] <= slice_s;
                  end
               end
               carry <= slice_c4;
               if (idx == IDX_LAST) begin
                  // idx parks on the last nibble; IDLE reloads it on accept.
                  cout_r <= slice_c4;
                  state  <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
